voice_envelope_mixer: RTL and testbench



---
 rtl/voice_env_pkg.sv | 32 +++
 rtl/voice_envelope_mixer_env.sv | 81 ++++++++
 rtl/voice_envelope_mixer.sv | 110 +++++++++++
 tb/tb_voice_envelope_mixer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_env_pkg.sv
// Shared types and constants for the four-voice envelope mixer.
// The scaling helper maps a 7-bit sample and an 8-bit envelope to a 0..127 level.
package voice_env_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam int unsigned NUM_VOICES = 4;
    localparam logic [6:0]  SAMPLE_MID = 7'd64;
    localparam logic [7:0]  ENV_MAX    = 8'd255;
    localparam logic [8:0]  MIX_RESET  = 9'd256;

    function automatic logic signed [16:0] env_product(input logic [6:0] sample,
                                                       input logic [7:0] env);
        logic signed [16:0] d17;
        logic signed [16:0] e17;
        d17 = 17'($signed({1'b0, sample} - {1'b0, SAMPLE_MID}));
        e17 = $signed({9'b0, env});
        return d17 * e17;
    endfunction

    // floor(p/256) lies in -64..62, so a 7-bit wraparound add re-centres it exactly.
    function automatic logic [6:0] env_scale(input logic signed [16:0] p);
        return 7'(p >>> 8) + SAMPLE_MID;
    endfunction

endpackage

// File: rtl/voice_envelope_mixer_env.sv
// One voice's ADSR state machine and envelope register.
// Gate edges take priority over the envelope step of a coincident tick.
module env_adsr
    import voice_env_pkg::*;
#(
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned DECAY_STEP   = 2,
    parameter int unsigned SUSTAIN_LVL  = 160,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       gate,
    output logic [7:0] env
);

    localparam logic [8:0] ATK9    = 9'(ATTACK_STEP);
    localparam logic [7:0] DEC8    = 8'(DECAY_STEP);
    localparam logic [7:0] SUS8    = 8'(SUSTAIN_LVL);
    localparam logic [8:0] DEC_LIM = 9'(SUSTAIN_LVL + DECAY_STEP);
    localparam logic [7:0] REL8    = 8'(RELEASE_STEP);

    env_state_t r_state;
    logic [7:0] r_env;
    logic       r_gate_d;
    logic       w_rise;
    logic       w_fall;
    logic [8:0] w_atk_sum;

    assign w_rise    = gate & ~r_gate_d;
    assign w_fall    = ~gate & r_gate_d;
    assign w_atk_sum = {1'b0, r_env} + ATK9;
    assign env       = r_env;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_env    <= '0;
            r_gate_d <= 1'b0;
        end else begin
            r_gate_d <= gate;
            if (w_rise) begin
                r_state <= ATTACK;
            end else if (w_fall && (r_state != IDLE)) begin
                r_state <= RELEASE;
            end else begin
                case (r_state)
                    IDLE: r_env <= '0;
                    ATTACK: if (tick) begin
                        if (w_atk_sum >= {1'b0, ENV_MAX}) begin
                            r_env   <= ENV_MAX;
                            r_state <= DECAY;
                        end else begin
                            r_env <= w_atk_sum[7:0];
                        end
                    end
                    DECAY: if (tick) begin
                        if ({1'b0, r_env} <= DEC_LIM) begin
                            r_env   <= SUS8;
                            r_state <= SUSTAIN;
                        end else begin
                            r_env <= r_env - DEC8;
                        end
                    end
                    SUSTAIN: r_env <= SUS8;
                    RELEASE: if (tick) begin
                        if (r_env <= REL8) begin
                            r_env   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_env <= r_env - REL8;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/voice_envelope_mixer.sv
// Four-voice ADSR envelope and mixer: shared tick prescaler, one time-multiplexed
// multiplier, and a 9-bit accumulator producing one mix per 4-clock frame.
module voice_envelope_mixer
    import voice_env_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 4096,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned DECAY_STEP   = 2,
    parameter int unsigned SUSTAIN_LVL  = 160,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] sample_in,
    input  logic [3:0]  gate,
    output logic [8:0]  mix_out,
    output logic        mix_valid
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]      r_presc;
    logic               w_tick;
    logic [7:0]         w_env [NUM_VOICES];

    logic [1:0]         r_slot;
    logic [1:0]         w_sel;
    logic [6:0]         r_snap_smp [NUM_VOICES];
    logic [7:0]         r_snap_env [NUM_VOICES];
    logic               r_snap_vld;
    logic signed [16:0] r_prod;
    logic [1:0]         r_prod_idx;
    logic               r_prod_vld;
    logic [8:0]         r_acc;
    logic               r_acc_done;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
        env_adsr #(
            .ATTACK_STEP (ATTACK_STEP),
            .DECAY_STEP  (DECAY_STEP),
            .SUSTAIN_LVL (SUSTAIN_LVL),
            .RELEASE_STEP(RELEASE_STEP)
        ) u_env (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (w_tick),
            .gate (gate[k]),
            .env  (w_env[k])
        );
    end

    // The multiplier lags the slot by one: slot 1..3,0 feed voices 0..3 of the
    // snapshot taken at slot 0, so voice 3 still reads the previous frame's copy.
    assign w_sel = r_slot - 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot     <= '0;
            r_snap_vld <= 1'b0;
            for (int unsigned k = 0; k < NUM_VOICES; k++) begin
                r_snap_smp[k] <= '0;
                r_snap_env[k] <= '0;
            end
            r_prod     <= '0;
            r_prod_idx <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_acc_done <= 1'b0;
            mix_out    <= MIX_RESET;
            mix_valid  <= 1'b0;
        end else begin
            r_slot <= r_slot + 2'd1;
            if (r_slot == 2'd0) begin
                for (int unsigned k = 0; k < NUM_VOICES; k++) begin
                    r_snap_smp[k] <= sample_in[7*k +: 7];
                    r_snap_env[k] <= w_env[k];
                end
                r_snap_vld <= 1'b1;
            end

            r_prod     <= env_product(r_snap_smp[w_sel], r_snap_env[w_sel]);
            r_prod_idx <= w_sel;
            r_prod_vld <= r_snap_vld;

            if (r_prod_vld) begin
                r_acc <= ((r_prod_idx == 2'd0) ? 9'd0 : r_acc) + {2'b00, env_scale(r_prod)};
            end
            r_acc_done <= r_prod_vld && (r_prod_idx == 2'd3);

            mix_valid <= r_acc_done;
            if (r_acc_done) begin
                mix_out <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_voice_envelope_mixer.sv
// Scoreboard bench for voice_envelope_mixer: a behavioural envelope model pushes the
// expected mix at every slot-0 snapshot; outputs are popped and compared on mix_valid.
module tb_voice_envelope_mixer;
    import voice_env_pkg::*;

    localparam int TD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] sample_in = '0;
    logic [3:0]  gate = '0;
    logic [8:0]  mix_out;
    logic        mix_valid;

    voice_envelope_mixer #(
        .TICK_DIV    (TD),
        .ATTACK_STEP (16),
        .DECAY_STEP  (2),
        .SUSTAIN_LVL (160),
        .RELEASE_STEP(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_in(sample_in),
        .gate     (gate),
        .mix_out  (mix_out),
        .mix_valid(mix_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int          mix;
        int unsigned stamp;
    } exp_t;

    exp_t        sb[$];
    int          m_presc;
    int          m_slot;
    int          m_env[4];
    env_state_t  m_st[4];
    logic [3:0]  m_gprev;
    int unsigned cyc = 0;

    function automatic int exp_scale(input int s, input int e);
        int p;
        p = (s - 64) * e;
        return 64 + (p >>> 8);
    endfunction

    // Reference model of the envelopes and frame timing.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_presc = 0;
                m_slot  = 0;
                m_gprev = '0;
                for (int k = 0; k < 4; k++) begin
                    m_env[k] = 0;
                    m_st[k]  = IDLE;
                end
                sb.delete();
            end else begin
                bit tk;
                cyc++;
                if (m_slot == 0) begin
                    exp_t e;
                    e.mix = 0;
                    for (int k = 0; k < 4; k++)
                        e.mix += exp_scale(int'(sample_in[7*k +: 7]), m_env[k]);
                    e.stamp = cyc;
                    sb.push_back(e);
                end
                m_slot  = (m_slot + 1) % 4;
                tk      = (m_presc == TD - 1);
                m_presc = tk ? 0 : m_presc + 1;
                for (int k = 0; k < 4; k++) begin
                    if (gate[k] && !m_gprev[k]) begin
                        m_st[k] = ATTACK;
                    end else if (!gate[k] && m_gprev[k] && m_st[k] != IDLE) begin
                        m_st[k] = RELEASE;
                    end else begin
                        case (m_st[k])
                            IDLE:    m_env[k] = 0;
                            SUSTAIN: m_env[k] = 160;
                            ATTACK: if (tk) begin
                                m_env[k] = m_env[k] + 16;
                                if (m_env[k] >= 255) begin m_env[k] = 255; m_st[k] = DECAY; end
                            end
                            DECAY: if (tk) begin
                                if (m_env[k] <= 162) begin m_env[k] = 160; m_st[k] = SUSTAIN; end
                                else m_env[k] = m_env[k] - 2;
                            end
                            RELEASE: if (tk) begin
                                m_env[k] = m_env[k] - 4;
                                if (m_env[k] <= 0) begin m_env[k] = 0; m_st[k] = IDLE; end
                            end
                            default: m_st[k] = IDLE;
                        endcase
                    end
                end
                m_gprev = gate;
            end
        end
    end

    // Output monitor: every mix_valid must match the oldest pending frame, 6 clocks on.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_t e;
                if (mix_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", mix_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("mix", mix_out, e.mix);
                        check("latency", cyc - e.stamp, 6);
                    end
                end else if (sb.size() > 0 && (cyc - sb[0].stamp) >= 6) begin
                    check("missing_valid", mix_valid, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic set_smp(input int v, input int val);
        sample_in[7*v +: 7] = 7'(val);
    endtask

    task automatic wait_env(input int v, input int val, input int maxc, input string tag);
        int n = 0;
        while (int'(dut.w_env[v]) != val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, dut.w_env[v], val);
    endtask

    task automatic wait_change(input int v, output int val);
        int old = int'(dut.w_env[v]);
        int n = 0;
        while (int'(dut.w_env[v]) == old && n < TD + 4) begin
            @(negedge clk);
            n++;
        end
        if (int'(dut.w_env[v]) == old) check("env_stall", dut.w_env[v] != 8'(old), 1);
        val = int'(dut.w_env[v]);
    endtask

    initial begin
        int v;
        int cnt;
        int n;
        int unsigned c0;

        repeat (3) @(negedge clk);
        set_smp(0, 100); set_smp(1, 20); set_smp(2, 90); set_smp(3, 40);
        rst_n = 1'b1;
        gate  = 4'hF;
        repeat (5 * TD + 2) @(negedge clk);

        // 1. Asynchronous reset mid-frame, gates held high.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mix", mix_out, 256);
        check("rst_valid", mix_valid, 0);
        check("rst_env0", dut.w_env[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        n = 0;
        while (!mix_valid && n < 20) begin @(negedge clk); n++; end
        check("first_valid_delay", cyc - c0, 7);
        check("first_mix", mix_out, 256);

        gate  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        set_smp(0, 127); set_smp(1, 64); set_smp(2, 64); set_smp(3, 64);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 2. Attack on voice 0.
        gate[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_change(0, v);
            check("atk_step", v, (16 * i > 255) ? 255 : 16 * i);
        end
        check("atk_state", dut.g_voice[0].u_env.r_state, DECAY);
        repeat (11) @(negedge clk);
        check("atk_mix", mix_out, 318);

        // 3. Decay into sustain.
        set_smp(0, 0);
        cnt = 0;
        while (int'(dut.w_env[0]) != 160 && cnt < 60) begin
            wait_change(0, v);
            cnt++;
        end
        check("decay_ticks", cnt, 48);
        check("sus_state", dut.g_voice[0].u_env.r_state, SUSTAIN);
        repeat (12) @(negedge clk);
        check("sus_mix", mix_out, 216);
        repeat (3 * TD) @(negedge clk);
        check("sus_mix_hold", mix_out, 216);
        check("sus_env_hold", dut.w_env[0], 160);

        // 4. Release to idle.
        gate[0] = 1'b0;
        cnt = 0;
        while (int'(dut.w_env[0]) != 0 && cnt < 50) begin
            wait_change(0, v);
            cnt++;
        end
        check("rel_ticks", cnt, 40);
        check("rel_state", dut.g_voice[0].u_env.r_state, IDLE);
        repeat (12) @(negedge clk);
        check("rel_mix", mix_out, 256);

        // 5. Retrigger during release at env 100.
        gate[0] = 1'b1;
        wait_env(0, 112, 10 * TD, "pre_rt_env");
        gate[0] = 1'b0;
        wait_env(0, 100, 5 * TD, "rt_start_env");
        gate[0] = 1'b1;
        wait_change(0, v);
        check("rt_first", v, 116);
        cnt = 1;
        while (v != 255 && cnt < 20) begin
            wait_change(0, v);
            cnt++;
        end
        check("rt_ticks", cnt, 10);

        // 6. Gate fall coincident with a tick during attack.
        gate[1] = 1'b1;
        wait_env(1, 48, 5 * TD, "co_env48");
        n = 0;
        while (m_presc != TD - 1 && n < 2 * TD) begin @(negedge clk); n++; end
        gate[1] = 1'b0;
        @(negedge clk);
        check("co_state", dut.g_voice[1].u_env.r_state, RELEASE);
        check("co_env_held", dut.w_env[1], 48);
        wait_change(1, v);
        check("co_first_rel", v, 44);

        gate = '0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
